// File: rtl/pwm_timebase.sv
// pwm_timebase: coarse PWM timebase with double-buffered period/compare values.
// A write taken while counting is held in a shadow and only becomes active
// together with the next tb==0 cycle, so a PWM cycle never mixes old and new
// settings. Optional macro PWM_TB_CLAMP_EN clamps captured compares whose
// coarse field lies beyond the captured period.
module pwm_timebase #(
    parameter int WIDTH  = 17,
    parameter int HRBITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [WIDTH-HRBITS-2:0]   wr_period,
    input  logic [WIDTH-2:0]          wr_cmpH,
    input  logic [WIDTH-2:0]          wr_cmpL,
    output logic [WIDTH-HRBITS-2:0]   tb,
    output logic [WIDTH-2:0]          cmpH,
    output logic [WIDTH-2:0]          cmpL,
    output logic                      sync,
    output logic                      upd_done
);

    localparam int CW = WIDTH - HRBITS - 1;  // coarse timebase width
    localparam int FW = WIDTH - 1;           // compare width (coarse:fine)

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    localparam logic [FW-1:0] CMPL_RST = FW'(50);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] tb_q, tb_d;
    logic          sync_q, sync_d;
    logic          upd_q, upd_d;
    logic          rdy_q, rdy_d;
    logic [CW-1:0] per_q, per_d;
    logic [FW-1:0] cmph_q, cmph_d;
    logic [FW-1:0] cmpl_q, cmpl_d;
    logic [CW-1:0] shp_q, shp_d;
    logic [FW-1:0] shh_q, shh_d;
    logic [FW-1:0] shl_q, shl_d;

    logic [FW-1:0] cap_h, cap_l;
    logic [CW-1:0] per_act;
    logic          accept, wrap;

`ifdef PWM_TB_CLAMP_EN
    // Pull compares that would never match back onto the last tb of the cycle
    always_comb begin
        cap_h = wr_cmpH;
        cap_l = wr_cmpL;
        if (wr_cmpH[FW-1:HRBITS] > wr_period) cap_h = {wr_period, {HRBITS{1'b0}}};
        if (wr_cmpL[FW-1:HRBITS] > wr_period) cap_l = {wr_period, {HRBITS{1'b0}}};
    end
`else
    assign cap_h = wr_cmpH;
    assign cap_l = wr_cmpL;
`endif

    // A zero period would stall the counter at 0; run it as a 2-cycle period
    assign per_act = (per_q == '0) ? CW'(1) : per_q;
    assign accept  = wr_valid && rdy_q;
    assign wrap    = (state_q != S_IDLE) && (tb_q == per_act);

    // Next-state: counter, sync, shadow capture and shadow->active transfer
    always_comb begin
        state_d = state_q;
        tb_d    = tb_q;
        sync_d  = 1'b0;
        upd_d   = 1'b0;
        per_d   = per_q;
        cmph_d  = cmph_q;
        cmpl_d  = cmpl_q;
        shp_d   = shp_q;
        shh_d   = shh_q;
        shl_d   = shl_q;
        if (!en) begin
            // Stopping: nothing to stay coherent with, so load right away
            state_d = S_IDLE;
            tb_d    = '0;
            if (state_q == S_PEND) begin
                per_d = shp_q; cmph_d = shh_q; cmpl_d = shl_q; upd_d = 1'b1;
            end else if (accept) begin
                per_d = wr_period; cmph_d = cap_h; cmpl_d = cap_l; upd_d = 1'b1;
            end
        end else if (state_q == S_IDLE) begin
            state_d = S_RUN;
            tb_d    = '0;
            sync_d  = 1'b1;
            if (accept) begin
                per_d = wr_period; cmph_d = cap_h; cmpl_d = cap_l; upd_d = 1'b1;
            end
        end else begin
            tb_d   = wrap ? '0 : tb_q + 1'b1;
            sync_d = wrap;
            if (state_q == S_PEND && wrap) begin
                per_d = shp_q; cmph_d = shh_q; cmpl_d = shl_q; upd_d = 1'b1;
                state_d = S_RUN;
            end
            // Only reachable from RUN (ready is low in PEND), so a write on
            // the wrap cycle waits for the following wrap
            if (accept) begin
                shp_d = wr_period; shh_d = cap_h; shl_d = cap_l;
                state_d = S_PEND;
            end
        end
        rdy_d = (state_d != S_PEND);
    end

    // State and output registers; reset drops any pending shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tb_q    <= '0;
            sync_q  <= 1'b0;
            upd_q   <= 1'b0;
            rdy_q   <= 1'b1;
            per_q   <= '1;
            cmph_q  <= '0;
            cmpl_q  <= CMPL_RST;
            shp_q   <= '0;
            shh_q   <= '0;
            shl_q   <= '0;
        end else begin
            state_q <= state_d;
            tb_q    <= tb_d;
            sync_q  <= sync_d;
            upd_q   <= upd_d;
            rdy_q   <= rdy_d;
            per_q   <= per_d;
            cmph_q  <= cmph_d;
            cmpl_q  <= cmpl_d;
            shp_q   <= shp_d;
            shh_q   <= shh_d;
            shl_q   <= shl_d;
        end
    end

    assign tb       = tb_q;
    assign sync     = sync_q;
    assign upd_done = upd_q;
    assign wr_ready = rdy_q;
    assign cmpH     = cmph_q;
    assign cmpL     = cmpl_q;

endmodule

// File: tb/tb_pwm_timebase.sv
// Bench for pwm_timebase: directed vector table, hand sequences for reset and
// the full-range count, then random traffic against a reference model.
module tb_pwm_timebase;

    localparam int CW = 13;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n, en, wr_valid, wr_ready, sync, upd_done;
    logic [CW-1:0] wr_period, tb;
    logic [FW-1:0] wr_cmpH, wr_cmpL, cmpH, cmpL;

    int nchk = 0;
    int nerr = 0;

    pwm_timebase dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_period(wr_period), .wr_cmpH(wr_cmpH), .wr_cmpL(wr_cmpL),
        .tb(tb), .cmpH(cmpH), .cmpL(cmpL), .sync(sync), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, wv;
        logic [CW-1:0] per;
        logic [FW-1:0] h, l;
        int            e_tb;
        logic          e_sync, e_upd, e_rdy;
        int            e_h, e_l;
    } vec_t;

    typedef struct {
        int per, h, l;
    } cfg_t;

    vec_t vq[$];

    // reference model state
    bit   m_run, m_sync, m_upd, m_rdy;
    int   m_tb;
    cfg_t act;
    cfg_t pend[$];

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
        end
    endfunction

    function automatic void add(logic e, logic w, int p, int h, int l,
                                int etb, logic es, logic eu, logic er, int eh, int el);
        vec_t v;
        v.en = e; v.wv = w; v.per = CW'(p); v.h = FW'(h); v.l = FW'(l);
        v.e_tb = etb; v.e_sync = es; v.e_upd = eu; v.e_rdy = er; v.e_h = eh; v.e_l = el;
        vq.push_back(v);
    endfunction

    function automatic int clampf(int c, int p);
`ifdef PWM_TB_CLAMP_EN
        if (c / 8 > p) return p * 8;
`endif
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0;
        wr_period = '0; wr_cmpH = '0; wr_cmpL = '0;
        step(); step();
        rst_n = 1'b1;
        m_run = 0; m_tb = 0; m_sync = 0; m_upd = 0; m_rdy = 1;
        act = '{8191, 0, 50};
        pend.delete();
    endtask

    // One clock of the specified behaviour, from the inputs present before the edge
    task automatic model_edge(bit e, bit w, int p, int h, int l);
        cfg_t nv;
        bit   acc;
        int   lim;
        nv  = '{p, clampf(h, p), clampf(l, p)};
        acc = w && (pend.size() == 0);
        lim = (act.per == 0) ? 1 : act.per;
        m_upd = 0; m_sync = 0;
        if (!e) begin
            if (pend.size() != 0) begin act = pend.pop_front(); m_upd = 1; end
            else if (acc)          begin act = nv;               m_upd = 1; end
            m_run = 0; m_tb = 0;
        end else if (!m_run) begin
            m_run = 1; m_tb = 0; m_sync = 1;
            if (acc) begin act = nv; m_upd = 1; end
        end else begin
            if (m_tb == lim) begin
                m_tb = 0; m_sync = 1;
                if (pend.size() != 0) begin act = pend.pop_front(); m_upd = 1; end
            end else begin
                m_tb++;
            end
            if (acc) pend.push_back(nv);
        end
        m_rdy = (pend.size() == 0);
    endtask

    int cl_exp;

    initial begin
`ifdef PWM_TB_CLAMP_EN
        cl_exp = 72;
`else
        cl_exp = 200;
`endif
        // load period 9 from IDLE, then start
        add(0,1,9,16,40,   0,0,1,1,16,40);
        add(1,0,0,0,0,     0,1,0,1,16,40);
        for (int t = 1; t <= 3; t++) add(1,0,0,0,0, t,0,0,1,16,40);
        // write at tb=3 -> pending until the wrap
        add(1,1,9,24,40,   4,0,0,0,16,40);
        add(1,0,0,0,0,     5,0,0,0,16,40);
        add(1,1,3,99,99,   6,0,0,0,16,40);   // ignored while not ready
        for (int t = 7; t <= 9; t++) add(1,0,0,0,0, t,0,0,0,16,40);
        add(1,0,0,0,0,     0,1,1,1,24,40);
        for (int t = 1; t <= 9; t++) add(1,0,0,0,0, t,0,0,1,24,40);
        // write on the wrap cycle -> takes effect one full period later
        add(1,1,9,32,40,   0,1,0,0,24,40);
        for (int t = 1; t <= 9; t++) add(1,0,0,0,0, t,0,0,0,24,40);
        add(1,0,0,0,0,     0,1,1,1,32,40);
        // period 0 behaves as 0,1,0,1
        add(0,1,0,32,40,   0,0,1,1,32,40);
        add(1,0,0,0,0,     0,1,0,1,32,40);
        add(1,0,0,0,0,     1,0,0,1,32,40);
        add(1,0,0,0,0,     0,1,0,1,32,40);
        add(1,0,0,0,0,     1,0,0,1,32,40);
        add(1,0,0,0,0,     0,1,0,1,32,40);
        // out-of-range falling compare
        add(0,1,9,0,200,   0,0,1,1,0,cl_exp);
        add(0,0,0,0,0,     0,0,0,1,0,cl_exp);

        do_reset();
        chk("rst_tb", tb, 0);
        chk("rst_sync", sync, 0);
        chk("rst_upd", upd_done, 0);
        chk("rst_ready", wr_ready, 1);
        chk("rst_cmpH", cmpH, 0);
        chk("rst_cmpL", cmpL, 50);

        // directed table
        foreach (vq[i]) begin
            en = vq[i].en; wr_valid = vq[i].wv;
            wr_period = vq[i].per; wr_cmpH = vq[i].h; wr_cmpL = vq[i].l;
            step();
            chk($sformatf("v%0d_tb", i), tb, vq[i].e_tb);
            chk($sformatf("v%0d_sync", i), sync, vq[i].e_sync);
            chk($sformatf("v%0d_upd", i), upd_done, vq[i].e_upd);
            chk($sformatf("v%0d_ready", i), wr_ready, vq[i].e_rdy);
            chk($sformatf("v%0d_cmpH", i), cmpH, vq[i].e_h);
            chk($sformatf("v%0d_cmpL", i), cmpL, vq[i].e_l);
        end
        wr_valid = 1'b0;

        // reset while a shadow is pending discards it
        do_reset();
        en = 1'b1;
        step(); step(); step();
        wr_valid = 1'b1; wr_period = 5; wr_cmpH = 77; wr_cmpL = 88;
        step();
        wr_valid = 1'b0;
        chk("pend_ready", wr_ready, 0);
        rst_n = 1'b0;
        step();
        chk("rstpend_ready", wr_ready, 1);
        chk("rstpend_upd", upd_done, 0);
        chk("rstpend_tb", tb, 0);
        rst_n = 1'b1; en = 1'b0;
        step();
        chk("rstpend_upd2", upd_done, 0);
        chk("rstpend_cmpH", cmpH, 0);
        chk("rstpend_cmpL", cmpL, 50);

        // full-range count with the reset period
        do_reset();
        en = 1'b1;
        for (int i = 0; i <= 8192; i++) begin
            step();
            chk("full_tb", tb, i % 8192);
            chk("full_sync", sync, (i % 8192) == 0);
        end
        chk("full_cmpH", cmpH, 0);
        chk("full_cmpL", cmpL, 50);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            en        = ($urandom_range(0, 24) != 0);
            wr_valid  = ($urandom_range(0, 3) == 0);
            wr_period = CW'($urandom_range(0, 12));
            wr_cmpH   = FW'($urandom_range(0, 127));
            wr_cmpL   = FW'($urandom_range(0, 127));
            model_edge(en, wr_valid, int'(wr_period), int'(wr_cmpH), int'(wr_cmpL));
            step();
            chk("rnd_tb", tb, m_tb);
            chk("rnd_sync", sync, m_sync);
            chk("rnd_upd", upd_done, m_upd);
            chk("rnd_ready", wr_ready, m_rdy);
            chk("rnd_cmpH", cmpH, act.h);
            chk("rnd_cmpL", cmpL, act.l);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pwm_timebase.md
PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 SHALL have parameter WIDTH, default 17, total compare width including sign/spare bit.
REQ-002 SHALL have parameter HRBITS, default 3, high-resolution (sub-clock) bits.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en, input, 1, timebase run enable.
REQ-006 SHALL have port wr_valid, input, 1, shadow write request.
REQ-007 SHALL have port wr_ready, output, 1, shadow can accept a write.
REQ-008 SHALL have port wr_period, input, WIDTH-HRBITS-1, new terminal count (last tb value of a cycle).
REQ-009 SHALL have port wr_cmpH, input, WIDTH-1, new rising-edge compare (coarse:fine).
REQ-010 SHALL have port wr_cmpL, input, WIDTH-1, new falling-edge compare (coarse:fine).
REQ-011 SHALL have port tb, output, WIDTH-HRBITS-1, coarse timebase to output-compare stage.
REQ-012 SHALL have port cmpH, output, WIDTH-1, active rising compare to output-compare stage.
REQ-013 SHALL have port cmpL, output, WIDTH-1, active falling compare to output-compare stage.
REQ-014 SHALL have port sync, output, 1, registered pulse, high exactly while tb==0 after a wrap.
REQ-015 SHALL have port upd_done, output, 1, one-cycle pulse when shadow values become active.

Function
REQ-016 SHALL implement states IDLE (en=0), RUN (en=1, no pending shadow), PEND (en=1, shadow pending).
REQ-017 In IDLE, tb SHALL be held at 0 and sync SHALL be 0.
REQ-018 IDLE->RUN on en=1; first counted cycle has tb=0 with sync=1.
REQ-019 In RUN/PEND, tb SHALL increment by 1 per clock; when tb==period_act, next tb SHALL be 0 (wrap).
REQ-020 sync SHALL be 1 on every cycle where tb is 0 due to a wrap or IDLE->RUN start, else 0.
REQ-021 en=0 in any state SHALL go to IDLE next cycle, tb=0; a pending shadow SHALL be applied immediately on that transition.
REQ-022 wr_ready SHALL be 1 in IDLE and RUN, 0 in PEND.
REQ-023 A write is accepted when wr_valid and wr_ready are both 1; wr_period/wr_cmpH/wr_cmpL captured into shadow that cycle.
REQ-024 Write accepted in IDLE: active period/cmpH/cmpL SHALL update next cycle, upd_done=1 that cycle.
REQ-025 Write accepted in RUN: state SHALL go PEND; active values unchanged until wrap.
REQ-026 In PEND, on the wrap cycle, active values SHALL load from shadow so they are valid with the tb=0 cycle; upd_done=1 coincident with sync; state->RUN.
REQ-027 A write accepted on a RUN wrap cycle SHALL take effect at the following wrap, never the current one.
REQ-028 period_act SHALL be max(period_reg, 1); period_reg==0 treated as 1 (tb sequence 0,1).
REQ-029 wr_valid while wr_ready=0 SHALL be ignored without side effect; the source must hold it.
REQ-030 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-031 On rst_n=0 at a clk edge: state IDLE, tb=0, sync=0, upd_done=0, wr_ready=1.
REQ-032 Reset values: period_reg all ones, cmpH=0, cmpL=50 decimal.
REQ-033 Reset mid-PEND SHALL discard the shadow; no upd_done is produced.

Configuration
REQ-034 Macro PWM_TB_CLAMP_EN: when defined, a captured wr_cmpH/wr_cmpL whose coarse field (bits WIDTH-2:HRBITS) exceeds the captured wr_period SHALL be clamped to {wr_period, HRBITS zeros}.
REQ-035 Without PWM_TB_CLAMP_EN, compare values SHALL pass through unmodified.

Verification
REQ-036 Reset, en=1, no writes -> tb 0..8191 then 0, sync at each tb=0, cmpH=0, cmpL=50.
REQ-037 In IDLE write period=9, cmpH=16, cmpL=40 -> next cycle active values, upd_done=1; en=1 gives tb period 10 cycles.
REQ-038 RUN period=9, write at tb=3 cmpH=24 -> wr_ready=0 tb 4..9; cmpH=24 and upd_done=1 with sync at tb=0.
REQ-039 Write on wrap cycle (tb=9) -> applied at next wrap (10 cycles later), not immediately.
REQ-040 Write period=0 -> tb toggles 0,1,0,1, sync every 2 cycles.
REQ-041 With PWM_TB_CLAMP_EN, period=9, cmpL=200 -> active cmpL=72; without macro cmpL=200.
